bike_mover: RTL

- Downstream consumer of the orientation word produced by the button-to-orientation stage.
- Advances one bike's pixel position by one step per game tick, in the direction given by that word.
- Detects border crashes and external trail collisions, and outputs the linear framebuffer address (y*SCREEN_W + x) for the renderer and collision RAM.
- Its crash output drives the orientation stage's crash input.

---
 rtl/bike_mover_pkg.sv | 14 +
 rtl/bike_mover_if.sv | 15 +
 rtl/bike_tick_gen.sv | 17 +
 rtl/bike_mover.sv | 94 +++++++++
 4 files changed

// File: rtl/bike_mover_pkg.sv
// bike_mover_pkg: orientation words shared with the orientation stage, state encoding and screen geometry
package bike_mover_pkg;
  localparam logic [31:0] ORIENT_RIGHT = 32'd1;
  localparam logic [31:0] ORIENT_LEFT = 32'hFFFF_FFFF;
  localparam logic [31:0] ORIENT_DOWN = 32'd640;
  localparam logic [31:0] ORIENT_UP = 32'hFFFF_FD80;
  localparam logic [31:0] ORIENT_STOP = 32'd0;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int L_W = 19;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CRASHED = 2'd2} state_t;
endpackage

// File: rtl/bike_mover_if.sv
// bike_mover_if: orientation/control in, position/status out between game logic and bike_mover
interface bike_mover_if;
  import bike_mover_pkg::*;
  logic [31:0] orient;
  logic start;
  logic crash_in;
  logic [L_W-1:0] location;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic moved;
  logic crash;
  logic running;
  modport master(output orient, start, crash_in, input location, pos_x, pos_y, moved, crash, running);
  modport slave(input orient, start, crash_in, output location, pos_x, pos_y, moved, crash, running);
endinterface

// File: rtl/bike_tick_gen.sv
// bike_tick_gen: movement tick every TICK_DIV cycles while enabled, counter held at zero otherwise
module bike_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input logic clock,
  input logic resetn,
  input logic en,
  input logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (en && !clr && !tick) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/bike_mover.sv
// bike_mover: steps one bike per game tick from the orientation word; define BIKE_MOVER_WRAP_EN to wrap at borders instead of crashing
module bike_mover
  import bike_mover_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int TICK_DIV = 250000,
  parameter int START_X = 100,
  parameter int START_Y = 240
) (
  input logic clock,
  input logic resetn,
  bike_mover_if.slave b
);
  localparam logic [X_W-1:0] X0 = X_W'(START_X);
  localparam logic [Y_W-1:0] Y0 = Y_W'(START_Y);
  localparam logic [L_W-1:0] L0 = L_W'(START_Y * SCREEN_W + START_X);
  localparam logic [L_W-1:0] ROW = L_W'(SCREEN_W);
  state_t state, state_n;
  logic tick, right, left, down, up, at_r, at_l, at_d, at_u, border, moved_n;
  logic [X_W-1:0] x_n, x_s;
  logic [Y_W-1:0] y_n, y_s;
  logic [L_W-1:0] l_n, l_s;
  assign right = b.orient == ORIENT_RIGHT;
  assign left = b.orient == ORIENT_LEFT;
  assign down = b.orient == ORIENT_DOWN;
  assign up = b.orient == ORIENT_UP;
  assign at_r = right && b.pos_x == X_W'(SCREEN_W - 1);
  assign at_l = left && b.pos_x == '0;
  assign at_d = down && b.pos_y == Y_W'(SCREEN_H - 1);
  assign at_u = up && b.pos_y == '0;
  assign b.crash = state == CRASHED;
  assign b.running = state == RUN;
`ifdef BIKE_MOVER_WRAP_EN
  assign border = 1'b0;
`else
  assign border = at_r || at_l || at_d || at_u;
`endif
  bike_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .resetn(resetn),
    .en(state == RUN),
    .clr(state_n != RUN),
    .tick(tick)
  );
  always_comb begin
    x_s = right ? b.pos_x + X_W'(1) : left ? b.pos_x - X_W'(1) : b.pos_x;
    y_s = down ? b.pos_y + Y_W'(1) : up ? b.pos_y - Y_W'(1) : b.pos_y;
    l_s = right ? b.location + L_W'(1) : left ? b.location - L_W'(1) :
          down ? b.location + ROW : up ? b.location - ROW : b.location;
`ifdef BIKE_MOVER_WRAP_EN
    x_s = at_r ? '0 : at_l ? X_W'(SCREEN_W - 1) : x_s;
    y_s = at_d ? '0 : at_u ? Y_W'(SCREEN_H - 1) : y_s;
    l_s = at_r ? b.location - L_W'(SCREEN_W - 1) : at_l ? b.location + L_W'(SCREEN_W - 1) :
          at_d ? b.location - L_W'((SCREEN_H - 1) * SCREEN_W) :
          at_u ? b.location + L_W'((SCREEN_H - 1) * SCREEN_W) : l_s;
`endif
  end
  always_comb begin
    state_n = state;
    x_n = b.pos_x;
    y_n = b.pos_y;
    l_n = b.location;
    moved_n = 1'b0;
    if (state != RUN) begin
      if (b.start) begin
        state_n = RUN;
        x_n = X0;
        y_n = Y0;
        l_n = L0;
      end
    end else if (b.crash_in || (tick && border)) state_n = CRASHED;
    else if (tick && (right || left || down || up)) begin
      x_n = x_s;
      y_n = y_s;
      l_n = l_s;
      moved_n = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      b.pos_x <= X0;
      b.pos_y <= Y0;
      b.location <= L0;
      b.moved <= 1'b0;
    end else begin
      state <= state_n;
      b.pos_x <= x_n;
      b.pos_y <= y_n;
      b.location <= l_n;
      b.moved <= moved_n;
    end
endmodule
